mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multi-cycle control sequencer for the MIPS datapath. It steps each instruction through fetch, decode, execute, memory and writeback states and drives the per-cycle datapath selects and write strobes. It shares one memory port between instruction fetch and data access, and stalls on a memory-ready handshake. It supports the same opcode set as the single-cycle control decoder: R-type, lw, sw, beq and j.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  6  instruction[31:26] taken from the datapath IR; sampled in DECODE and later states.
- mem_ready  in  1  memory completes the current read or write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by ALU zero (the datapath ANDs it with zero).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  IR load.
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  destination register: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B input: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = use funct.
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state code, for debug.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

## Operation
- Moore FSM with a 4-bit state register. All outputs decode from the state. IRWrite, PCWrite (FETCH only), the MEMWR MemWrite-completion and instr_done are additionally gated by mem_ready where noted. Any output not listed for a state is 0.
- States and codes:
  - FETCH=0: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready. Goes to DECODE when mem_ready=1, otherwise holds.
  - DECODE=1: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
    - 000000 → EXEC
    - 100011 or 101011 → MEMADR
    - 000100 → BRANCH
    - 000010 → JUMP
    - any other opcode → FETCH, with illegal_op=1 and instr_done=1 (executes as a NOP).
  - MEMADR=2: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD if opcode=100011, else MEMWR.
  - MEMRD=3: MemRead=1, IorD=1. Goes to MEMWB on mem_ready, otherwise holds.
  - MEMWB=4: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Goes to FETCH.
  - MEMWR=5: MemWrite=1, IorD=1, instr_done=mem_ready. Goes to FETCH on mem_ready, otherwise holds.
  - EXEC=6: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RWB.
  - RWB=7: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Goes to FETCH.
  - BRANCH=8: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Goes to FETCH.
  - JUMP=9: PCWrite=1, PCSource=10, instr_done=1. Goes to FETCH.
- Codes 10–15 are unreachable. If the state register ever holds one, all outputs are 0 and the next state is FETCH.
- MemRead and MemWrite are never 1 in the same cycle.
- Request signals (MemRead, MemWrite, IorD) stay stable for every stall cycle of a memory state.
- The IR holds opcode from the FETCH exit edge until the next FETCH. The controller keeps no copy of it.

## Timing
- Reset while rst_n=0:
  - state is forced to FETCH immediately (asynchronous).
  - PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, instr_done and illegal_op are forced to 0, regardless of mem_ready.
  - The other outputs take their FETCH values: MemRead=1, ALUSrcB=01, all remaining selects 0.
- First edge after rst_n rises: FETCH proceeds normally.
- Reset asserted mid-instruction, including during a memory stall, aborts the instruction. No strobe may glitch high during the reset.
- Cycle counts with mem_ready held at 1:
  - lw: 5 cycles.
  - R-type and sw: 4 cycles.
  - beq and j: 3 cycles.
  - illegal opcode: 2 cycles.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_ready is ignored in every other state.
- instr_done is high for exactly one cycle per instruction. The next edge always enters FETCH.

## Test plan
- Reset: hold rst_n=0 with mem_ready=1 → state=0, MemRead=1, PCWrite=IRWrite=0. Release → PCWrite=IRWrite=1 in the first FETCH cycle.
- R-type back-to-back with mem_ready=1 → state sequence 0,1,6,7,0,1,6,7. RegWrite=1 and RegDst=1 only in state 7. instr_done pulses every 4 cycles.
- lw with mem_ready low for 3 cycles in MEMRD → sequence 0,1,2,3,3,3,3,4,0. MemRead=1 and IorD=1 are held throughout state 3. Total 8 cycles.
- sw with mem_ready=0 for 2 cycles in FETCH → IRWrite stays 0 until mem_ready rises. In MEMWR, MemWrite=1 with instr_done coincident with mem_ready.
- beq then j → state 8 drives PCWriteCond=1, PCSource=01, ALUOp=01. State 9 drives PCWrite=1, PCSource=10. Each takes 3 cycles.
- opcode=001000 and rst_n pulsed low during MEMRD:
  - illegal opcode → illegal_op=1 for one cycle, then 0,1,0.
  - reset pulse → state returns to 0 asynchronously, with no RegWrite pulse.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: Moore FSM stepping FETCH..WRITEBACK,
// sharing one memory port between instruction fetch and data access.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4, S_MEMWR  = 4'd5, S_EXEC   = 4'd6, S_RWB   = 4'd7,
    S_BRANCH = 4'd8, S_JUMP   = 4'd9
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e state_q, state_d;
  logic   pcw_d, pcwc_d, mwr_d, irw_d, rw_d, done_d, ill_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = S_FETCH;
    pcw_d    = 1'b0;
    pcwc_d   = 1'b0;
    mwr_d    = 1'b0;
    irw_d    = 1'b0;
    rw_d     = 1'b0;
    done_d   = 1'b0;
    ill_d    = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSource = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        irw_d   = mem_ready;
        pcw_d   = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            // Unsupported opcode retires as a NOP straight back to fetch.
            state_d = S_FETCH;
            ill_d   = 1'b1;
            done_d  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        rw_d     = 1'b1;
        done_d   = 1'b1;
      end
      S_MEMWR: begin
        mwr_d   = 1'b1;
        IorD    = 1'b1;
        done_d  = mem_ready;
        state_d = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegDst = 1'b1;
        rw_d   = 1'b1;
        done_d = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        pcwc_d   = 1'b1;
        PCSource = 2'b01;
        done_d   = 1'b1;
      end
      S_JUMP: begin
        pcw_d    = 1'b1;
        PCSource = 2'b10;
        done_d   = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are masked by reset so nothing writes while rst_n is low.
  assign PCWrite     = pcw_d  & rst_n;
  assign PCWriteCond = pcwc_d & rst_n;
  assign MemWrite    = mwr_d  & rst_n;
  assign IRWrite     = irw_d  & rst_n;
  assign RegWrite    = rw_d   & rst_n;
  assign instr_done  = done_d & rst_n;
  assign illegal_op  = ill_d  & rst_n;
  assign state       = state_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed vector table, reset-abort corner
// case, and random instruction streams against an instruction-plan model.
module tb_mips_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, mem_ready;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2B, BQ = 6'h04, JP = 6'h02, IL = 6'h08;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  logic [18:0] outv;
  assign outv = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                 RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op};

  function automatic logic legal(input logic [5:0] opc);
    return (opc == R) || (opc == LW) || (opc == SW) || (opc == BQ) || (opc == JP);
  endfunction

  // Expected output vector for a state code, straight from the per-state table.
  function automatic logic [18:0] exp_out(input int st, input logic mr, input logic [5:0] opc,
                                          input logic rn);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, done, ill;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, done, ill} = '0;
    asb = 2'd0; aop = 2'd0; pcs = 2'd0;
    case (st)
      0: begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1: begin asb = 2'b11; ill = !legal(opc); done = !legal(opc); end
      2: begin asa = 1; asb = 2'b10; end
      3: begin mrd = 1; iord = 1; end
      4: begin m2r = 1; rw = 1; done = 1; end
      5: begin mwr = 1; iord = 1; done = mr; end
      6: begin asa = 1; aop = 2'b10; end
      7: begin rdst = 1; rw = 1; done = 1; end
      8: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
      9: begin pcw = 1; pcs = 2'b10; done = 1; end
      default: ;
    endcase
    if (!rn) {pcw, pcwc, irw, rw, mwr, done, ill} = '0;
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, done, ill};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, compare 2ns later.
  task automatic cyc(input logic rn, input logic [5:0] opc, input logic mr, input int est,
                     input string nm);
    @(negedge clk);
    rst_n = rn; opcode = opc; mem_ready = mr;
    #2;
    chk({nm, " state"}, 32'(state), 32'(est));
    chk({nm, " outs"}, 32'(outv), 32'(exp_out(est, mr, opc, rn)));
  endtask

  typedef struct {
    logic       rn;
    logic [5:0] opc;
    logic       mr;
    int         st;
    logic       done;
    logic       ill;
  } vec_t;

  vec_t tbl[$];
  int   q[$];

  initial begin
    logic [5:0] ropc;
    logic       rmr;
    int         cur;
    rst_n = 1'b0; mem_ready = 1'b1; opcode = R;
    repeat (2) @(posedge clk);

    // rst, opcode, mem_ready, state, instr_done, illegal_op
    tbl.push_back('{0, R, 1, 0, 0, 0});
    tbl.push_back('{1, R, 1, 0, 0, 0});
    tbl.push_back('{1, R, 1, 1, 0, 0});
    tbl.push_back('{1, R, 1, 6, 0, 0});
    tbl.push_back('{1, R, 1, 7, 1, 0});
    tbl.push_back('{1, R, 1, 0, 0, 0});
    tbl.push_back('{1, R, 1, 1, 0, 0});
    tbl.push_back('{1, R, 1, 6, 0, 0});
    tbl.push_back('{1, R, 1, 7, 1, 0});
    tbl.push_back('{1, LW, 1, 0, 0, 0});
    tbl.push_back('{1, LW, 1, 1, 0, 0});
    tbl.push_back('{1, LW, 1, 2, 0, 0});
    tbl.push_back('{1, LW, 0, 3, 0, 0});
    tbl.push_back('{1, LW, 0, 3, 0, 0});
    tbl.push_back('{1, LW, 0, 3, 0, 0});
    tbl.push_back('{1, LW, 1, 3, 0, 0});
    tbl.push_back('{1, LW, 0, 4, 1, 0});
    tbl.push_back('{1, SW, 0, 0, 0, 0});
    tbl.push_back('{1, SW, 0, 0, 0, 0});
    tbl.push_back('{1, SW, 1, 0, 0, 0});
    tbl.push_back('{1, SW, 1, 1, 0, 0});
    tbl.push_back('{1, SW, 1, 2, 0, 0});
    tbl.push_back('{1, SW, 0, 5, 0, 0});
    tbl.push_back('{1, SW, 1, 5, 1, 0});
    tbl.push_back('{1, BQ, 1, 0, 0, 0});
    tbl.push_back('{1, BQ, 0, 1, 0, 0});
    tbl.push_back('{1, BQ, 0, 8, 1, 0});
    tbl.push_back('{1, JP, 1, 0, 0, 0});
    tbl.push_back('{1, JP, 1, 1, 0, 0});
    tbl.push_back('{1, JP, 1, 9, 1, 0});
    tbl.push_back('{1, IL, 1, 0, 0, 0});
    tbl.push_back('{1, IL, 1, 1, 1, 1});
    tbl.push_back('{1, IL, 1, 0, 0, 0});
    tbl.push_back('{1, R, 1, 1, 0, 0});
    tbl.push_back('{1, R, 1, 6, 0, 0});

    foreach (tbl[i]) begin
      cyc(tbl[i].rn, tbl[i].opc, tbl[i].mr, tbl[i].st, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d done", i), 32'(instr_done), 32'(tbl[i].done));
      chk($sformatf("vec%0d ill", i), 32'(illegal_op), 32'(tbl[i].ill));
    end
    cyc(1, R, 1, 7, "rtype tail");

    // Reset asserted mid-cycle during a MEMRD stall aborts the load.
    cyc(1, LW, 1, 0, "abort");
    cyc(1, LW, 1, 1, "abort");
    cyc(1, LW, 1, 2, "abort");
    cyc(1, LW, 0, 3, "abort");
    cyc(1, LW, 0, 3, "abort");
    rst_n = 1'b0;
    #1;
    chk("async rst state", 32'(state), 32'd0);
    chk("async rst RegWrite", 32'(RegWrite), 32'd0);
    chk("async rst outs", 32'(outv), 32'(exp_out(0, 1'b0, LW, 1'b0)));
    cyc(0, LW, 1, 0, "rst held");
    chk("rst held RegWrite", 32'(RegWrite), 32'd0);
    cyc(0, LW, 0, 0, "rst held mr0");
    cyc(1, LW, 1, 0, "rst release");
    cyc(1, LW, 1, 1, "rst release");
    cyc(0, R, 1, 0, "resync");

    // Random streams against an instruction-plan model: each instruction is a
    // list of state codes; FETCH/MEMRD/MEMWR repeat while mem_ready is low.
    ropc = R;
    for (int c = 0; c < 600; c++) begin
      if (q.size() == 0) begin
        case ($urandom_range(0, 5))
          0: ropc = R;
          1: ropc = LW;
          2: ropc = SW;
          3: ropc = BQ;
          4: ropc = JP;
          default: begin
            ropc = 6'($urandom_range(0, 63));
            while (legal(ropc)) ropc = 6'($urandom_range(0, 63));
          end
        endcase
        q = '{0, 1};
        if (ropc == R) begin q.push_back(6); q.push_back(7); end
        else if (ropc == LW) begin q.push_back(2); q.push_back(3); q.push_back(4); end
        else if (ropc == SW) begin q.push_back(2); q.push_back(5); end
        else if (ropc == BQ) q.push_back(8);
        else if (ropc == JP) q.push_back(9);
      end
      rmr = ($urandom_range(0, 3) != 0);
      cur = q[0];
      cyc(1, ropc, rmr, cur, $sformatf("rnd%0d", c));
      if (!((cur == 0 || cur == 3 || cur == 5) && !rmr)) void'(q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
